// File: rtl/ds1302_link_if.sv
// Host-side handshake bundle for the DS1302 3-wire link master.
// The master modport is the requester (the clock-keeping controller);
// the slave modport is the link block itself.
interface ds1302_link_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, output cmd, output wdata,
                  input  busy,  input  done, input  rdata);
  modport slave  (input  start, input  cmd,  input  wdata,
                  output busy,  output done, output rdata);
endinterface

// File: rtl/ds1302_link.sv
// Bit-level master for the DS1302 RTC 3-wire bus (CE, SCLK, DATA).
// One command byte plus one data byte per accepted start, both LSB first.
// Optional feature macro: DS1302_WP_CLEAR_EN -- when defined, the block
// issues one silent write of 8'h00 to register 8'h8E (write-protect
// clear) right after reset, with no done strobe and user starts ignored.
module ds1302_link #(
  parameter int CLK_DIV  = 50,
  parameter int CE_SETUP = 200
) (
  input  logic            clk,
  input  logic            rst,
  ds1302_link_if.slave    bus,
  output logic            SCLK,
  output logic            CE,
  inout  wire             DATA
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int            CW         = 16;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CE_SETUP - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;      // cycles spent in the current interval/phase
  logic [3:0]    bit_q;      // current bit slot 0..15
  logic          phase_q;    // 0 = SCLK low phase, 1 = SCLK high phase
  logic [15:0]   tx_q;       // {wdata, cmd} latched at launch
  logic          rd_q;       // latched cmd[0]
  logic          quiet_q;    // transaction must not raise done
  logic [7:0]    rx_q;       // read shift register, LSB arrives first
  logic [7:0]    rdata_q;
  logic          ce_q;
  logic          sclk_q;
  logic          dout_q;
  logic          doe_q;
  logic          busy_q;
  logic          done_q;
`ifdef DS1302_WP_CLEAR_EN
  logic          wp_pend_q;  // write-protect clear still owed after reset
`endif

  logic          launch_d;
  logic [15:0]   launch_tx_d;
  logic          launch_quiet_d;
  logic [3:0]    nxt_bit_d;
  logic          nxt_val_d;
  logic          nxt_oe_d;

  // Launch request selection and next-slot DATA drive values
  always_comb begin
    launch_d       = 1'b0;
    launch_tx_d    = {bus.wdata, bus.cmd};
    launch_quiet_d = 1'b0;
`ifdef DS1302_WP_CLEAR_EN
    if (wp_pend_q) begin
      launch_d       = 1'b1;
      launch_tx_d    = {8'h00, 8'h8E};
      launch_quiet_d = 1'b1;
    end else begin
      launch_d       = bus.start;
    end
`else
    launch_d       = bus.start;
`endif
    nxt_bit_d = bit_q + 4'd1;
    nxt_val_d = tx_q[nxt_bit_d];
    // Data slots of a read release the line to the slave
    if (rd_q && nxt_bit_d[3]) begin
      nxt_oe_d = 1'b0;
    end else begin
      nxt_oe_d = 1'b1;
    end
  end

  // Transaction FSM with all pin and handshake outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      phase_q   <= 1'b0;
      tx_q      <= 16'h0000;
      rd_q      <= 1'b0;
      quiet_q   <= 1'b0;
      rx_q      <= 8'h00;
      rdata_q   <= 8'h00;
      ce_q      <= 1'b0;
      sclk_q    <= 1'b0;
      dout_q    <= 1'b0;
      doe_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DS1302_WP_CLEAR_EN
      wp_pend_q <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ce_q   <= 1'b0;
          sclk_q <= 1'b0;
          doe_q  <= 1'b0;
          busy_q <= 1'b0;
          if (launch_d) begin
            tx_q      <= launch_tx_d;
            rd_q      <= launch_tx_d[0];
            quiet_q   <= launch_quiet_d;
            cnt_q     <= '0;
            ce_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
`ifdef DS1302_WP_CLEAR_EN
            wp_pend_q <= 1'b0;
`endif
          end else begin
            cnt_q <= '0;
          end
        end

        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            // Slot 0 low phase starts: put cmd[0] on the line
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
            dout_q  <= tx_q[0];
            doe_q   <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!phase_q) begin
              // End of low phase: sample read data, then raise SCLK
              phase_q <= 1'b1;
              sclk_q  <= 1'b1;
              if (rd_q && bit_q[3]) begin
                rx_q <= {DATA, rx_q[7:1]};
              end else begin
                rx_q <= rx_q;
              end
            end else begin
              // End of high phase: drop SCLK, move to next slot or HOLD
              phase_q <= 1'b0;
              sclk_q  <= 1'b0;
              if (bit_q == 4'd15) begin
                state_q <= ST_HOLD;
              end else begin
                bit_q  <= nxt_bit_d;
                dout_q <= nxt_val_d;
                doe_q  <= nxt_oe_d;
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_HOLD: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            doe_q   <= 1'b0;
            done_q  <= ~quiet_q;
            state_q <= ST_RECOVER;
            if (rd_q) begin
              rdata_q <= rx_q;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_RECOVER: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          ce_q    <= 1'b0;
          sclk_q  <= 1'b0;
          doe_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SCLK      = sclk_q;
  assign CE        = ce_q;
  assign DATA      = doe_q ? dout_q : 1'bz;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ds1302_link.sv
// Self-checking bench for ds1302_link with a DS1302 pin-level slave model.
// Expected values come from the transaction rules: bit order, edge counts
// and cycle positions computed from CLK_DIV and CE_SETUP.
// Handles builds with or without DS1302_WP_CLEAR_EN.
module tb_ds1302_link;

  localparam int CD = 2;
  localparam int CS = 4;
  localparam int T_DONE = 1 + 2*CS + 32*CD;
  localparam int T_FALL = T_DONE + CS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SCLK;
  logic CE;
  wire  DATA;

  logic       s_oe = 1'b0;
  logic       s_val = 1'b0;
  assign DATA = s_oe ? s_val : 1'bz;

  ds1302_link_if bus ();

  ds1302_link #(.CLK_DIV(CD), .CE_SETUP(CS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .SCLK (SCLK),
    .CE   (CE),
    .DATA (DATA)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state (only ever accumulated; the bench works with differences)
  int          cyc = 0;
  int          rises_total = 0;
  logic [15:0] cap = 16'h0000;
  int          ce_hi = 0;
  int          low_run = 0;
  int          last_gap = 0;
  int          done_tot = 0;
  int          done_at = 0;
  int          fall_at = 0;
  int          viol = 0;
  logic [7:0]  rd_at_done = 8'h00;
  logic        prev_ce = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_data = 1'b0;

  // Slave model controls and reference state
  logic        slave_rd = 1'b0;
  logic [7:0]  slave_byte = 8'h00;
  int          rise_base = 0;
  logic [7:0]  exp_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Capture DATA on every SCLK rise, LSB first
  always @(posedge SCLK) begin
    cap         <= {DATA, cap[15:1]};
    rises_total <= rises_total + 1;
  end

  // Slave drives read data bits after SCLK falls in slots 8..15
  always @(negedge SCLK or posedge rst) begin
    if (rst) begin
      s_oe <= 1'b0;
    end else if (slave_rd && (rises_total - rise_base) >= 8 && (rises_total - rise_base) < 16) begin
      s_oe  <= 1'b1;
      s_val <= slave_byte[rises_total - rise_base - 8];
    end else begin
      s_oe <= 1'b0;
    end
  end

  // Mid-cycle observation of CE, done, busy and DATA stability
  always @(negedge clk) begin
    if (CE) ce_hi <= ce_hi + 1;
    if (CE && !prev_ce) last_gap <= low_run;
    low_run <= CE ? 0 : low_run + 1;
    if (bus.done) begin
      done_tot   <= done_tot + 1;
      done_at    <= cyc;
      rd_at_done <= bus.rdata;
    end
    if (prev_busy && !bus.busy) fall_at <= cyc;
    if (SCLK && prev_sclk && (DATA !== prev_data)) viol <= viol + 1;
    prev_ce   <= CE;
    prev_busy <= bus.busy;
    prev_sclk <= SCLK;
    prev_data <= DATA;
  end

  // Full transaction: start now, wait for busy to drop, check everything
  task automatic txn(input logic [7:0] c, input logic [7:0] w, input logic [7:0] sb, input string tag);
    int t0, cb, db, vb, to;
    logic [15:0] exp_bits;
    rise_base  = rises_total;
    cb         = ce_hi;
    db         = done_tot;
    vb         = viol;
    slave_rd   = c[0];
    slave_byte = sb;
    bus.cmd    = c;
    bus.wdata  = w;
    bus.start  = 1'b1;
    t0         = cyc;
    tick();
    bus.start  = 1'b0;
    check({tag, "_ce_rise"}, {31'd0, CE}, 32'd1);
    check({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
    to = 0;
    do begin
      tick();
      to++;
    end while (bus.busy && to < 2000);
    check({tag, "_timeout"}, (to < 2000) ? 32'd1 : 32'd0, 32'd1);
    exp_bits = c[0] ? {sb, c} : {w, c};
    if (c[0]) exp_rdata = sb;
    check({tag, "_bits"}, {16'd0, cap}, {16'd0, exp_bits});
    check({tag, "_rises"}, rises_total - rise_base, 32'd16);
    check({tag, "_ce_len"}, ce_hi - cb, 2*CS + 32*CD);
    check({tag, "_done_cnt"}, done_tot - db, 32'd1);
    check({tag, "_done_at"}, done_at - t0, T_DONE);
    check({tag, "_busy_fall"}, fall_at - t0, T_FALL);
    check({tag, "_rdata_done"}, {24'd0, rd_at_done}, {24'd0, exp_rdata});
    check({tag, "_rdata"}, {24'd0, bus.rdata}, {24'd0, exp_rdata});
    check({tag, "_data_stable"}, viol - vb, 32'd0);
    slave_rd = 1'b0;
  endtask

  // Post-reset behaviour: optional silent write-protect clear, else idle
  task automatic after_reset();
    int rb, db, to;
    rb = rises_total;
    db = done_tot;
    slave_rd = 1'b0;
`ifdef DS1302_WP_CLEAR_EN
    tick();
    check("wp_busy", {31'd0, bus.busy}, 32'd1);
    bus.cmd   = 8'h81;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    to = 0;
    while (bus.busy && to < 2000) begin
      tick();
      to++;
    end
    check("wp_timeout", (to < 2000) ? 32'd1 : 32'd0, 32'd1);
    check("wp_bits", {16'd0, cap}, 32'h0000_008E);
    check("wp_rises", rises_total - rb, 32'd16);
    check("wp_no_done", done_tot - db, 32'd0);
    tick();
    check("wp_user_ignored", {31'd0, bus.busy}, 32'd0);
`else
    repeat (20) tick();
    check("idle_rises", rises_total - rb, 32'd0);
    check("idle_ce", {31'd0, CE}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done", done_tot - db, 32'd0);
`endif
  endtask

  initial begin
    int t0, db, to, rb;
    logic [7:0] c, w, sb;
    bus.start = 1'b0;
    bus.cmd   = 8'h00;
    bus.wdata = 8'h00;
    repeat (3) tick();
    check("rst_ce", {31'd0, CE}, 32'd0);
    check("rst_sclk", {31'd0, SCLK}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    rst = 1'b0;
    after_reset();

    // Directed write and read
    txn(8'h80, 8'h59, 8'h00, "wr5980");
    txn(8'h81, 8'h5A, 8'hA5, "rdA5");

    // start while busy, and start on the last RECOVER cycle, are ignored
    db = done_tot;
    bus.cmd   = 8'h82;
    bus.wdata = 8'h3C;
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc - t0 < 20) tick();
    bus.cmd   = 8'h85;
    bus.wdata = 8'hC3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc - t0 < T_FALL - 1) tick();
    check("ign_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign_not_accepted", {31'd0, bus.busy}, 32'd0);
    check("ign_bits", {16'd0, cap}, 32'h0000_3C82);
    check("ign_done_cnt", done_tot - db, 32'd1);
    txn(8'hC1, 8'h00, 8'h6E, "after_ign");

    // Reset in the middle of SHIFT
    rb = rise_base;
    rise_base = rises_total;
    bus.cmd   = 8'h90;
    bus.wdata = 8'hF0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    to = 0;
    while ((rises_total - rise_base) < 5 && to < 500) begin
      tick();
      to++;
    end
    check("mid_timeout", (to < 500) ? 32'd1 : 32'd0, 32'd1);
    db = done_tot;
    rst = 1'b1;
    #1;
    check("mid_ce", {31'd0, CE}, 32'd0);
    check("mid_sclk", {31'd0, SCLK}, 32'd0);
    check("mid_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_done", {31'd0, bus.done}, 32'd0);
    repeat (5) tick();
    rst = 1'b0;
    exp_rdata = 8'h00;
    rise_base = rb;
    check("mid_no_done", done_tot - db, 32'd0);
    after_reset();
    txn(8'h80, 8'h17, 8'h00, "post_rst");

    // Back-to-back reads of 00 then FF
    txn(8'h81, $urandom_range(255, 0), 8'h00, "b2b_00");
    txn(8'h81, $urandom_range(255, 0), 8'hFF, "b2b_FF");
    check("b2b_gap", (last_gap >= CS) ? 32'd1 : 32'd0, 32'd1);

    // Randomised transactions
    for (int i = 0; i < 8; i++) begin
      c  = 8'($urandom_range(255, 0));
      w  = 8'($urandom_range(255, 0));
      sb = 8'($urandom_range(255, 0));
      txn(c, w, sb, $sformatf("rnd%0d", i));
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
